ddr_density_counter: RTL and testbench

// - Consumes the two samples per clk cycle produced by the feedback path's dual-edge

---
 rtl/ddr_density_counter.sv | 91 +++++++++
 tb/tb_ddr_density_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ddr_density_counter.sv
// rtl/ddr_density_counter.sv - windowed ones/transition counter for a dual-edge sample pair
// Results are handed out over a valid/ready port; a window ending while a result is unaccepted is dropped.
module ddr_density_counter #(
  parameter int WIN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIN_W-1:0]   win_len,
  input  logic               s_rise,
  input  logic               s_fall,
  output logic [WIN_W+1:0]   cnt_out,
  output logic [WIN_W+1:0]   trans_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
);

  localparam int CNT_W = WIN_W + 2;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] tacc;
  logic             prev;
  logic [WIN_W-1:0] wcnt;

  logic [1:0]       ones;
  logic [1:0]       trans;
  logic [WIN_W-1:0] cur;
  logic             win_end;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W-1:0] tacc_nxt;
  logic             accept;

  // The start cycle out of IDLE is the first sample of the window, so it
  // uses win_len directly as its remaining-cycle count.
  always_comb begin
    ones     = {1'b0, s_rise} + {1'b0, s_fall};
    trans    = {1'b0, s_rise ^ prev} + {1'b0, s_fall ^ s_rise};
    cur      = (state == IDLE) ? win_len : wcnt;
    win_end  = en && (cur == '0);
    acc_nxt  = acc + CNT_W'(ones);
    tacc_nxt = tacc + CNT_W'(trans);
    accept   = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tacc      <= '0;
      prev      <= 1'b0;
      wcnt      <= '0;
      cnt_out   <= '0;
      trans_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (en) begin
        state <= ACCUM;
        prev  <= s_fall;
        if (win_end) begin
          acc  <= '0;
          tacc <= '0;
          wcnt <= win_len;
        end else begin
          acc  <= acc_nxt;
          tacc <= tacc_nxt;
          wcnt <= cur - 1'b1;
        end
      end else begin
        // Leaving ACCUM abandons the partial window; prev is kept.
        state <= IDLE;
        acc   <= '0;
        tacc  <= '0;
      end

      if (win_end && (!out_valid || out_ready)) begin
        cnt_out   <= acc_nxt;
        trans_out <= tacc_nxt;
        out_valid <= 1'b1;
      end else begin
        if (win_end) overrun <= 1'b1;
        if (accept)  out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_density_counter.sv
// tb/tb_ddr_density_counter.sv - directed self-checking bench for ddr_density_counter
module tb_ddr_density_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] win_len;
  logic       s_rise;
  logic       s_fall;
  logic [9:0] cnt_out;
  logic [9:0] trans_out;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  ddr_density_counter #(.WIN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .win_len   (win_len),
    .s_rise    (s_rise),
    .s_fall    (s_fall),
    .cnt_out   (cnt_out),
    .trans_out (trans_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pair(input logic r, input logic f);
    s_rise = r;
    s_fall = f;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; win_len = 8'd0; out_ready = 1'b0;
    set_pair(1'b0, 1'b0);
    tick(3);
    check("rst_cnt", cnt_out, 0);
    check("rst_trans", trans_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);

    // 4-cycle window of all ones, prev starts at 0
    rst = 1'b0; en = 1'b1; win_len = 8'd3; set_pair(1'b1, 1'b1);
    tick(3);
    check("w1_not_yet", out_valid, 0);
    tick(1);
    check("w1_valid", out_valid, 1);
    check("w1_cnt", cnt_out, 8);
    check("w1_trans", trans_out, 1);
    check("w1_overrun", overrun, 0);

    en = 1'b0; out_ready = 1'b1;
    tick(1);
    check("w1_accept", out_valid, 0);
    check("w1_hold_cnt", cnt_out, 8);

    // one-cycle windows, alternating pair; prev is 1 on entry
    en = 1'b1; win_len = 8'd0; set_pair(1'b1, 1'b0);
    tick(1);
    check("alt_first_cnt", cnt_out, 1);
    check("alt_first_trans", trans_out, 1);
    tick(1);
    check("alt_valid", out_valid, 1);
    check("alt_cnt", cnt_out, 1);
    check("alt_trans", trans_out, 2);
    tick(1);
    check("alt_valid_nogap", out_valid, 1);
    check("alt_trans2", trans_out, 2);
    check("alt_overrun", overrun, 0);

    en = 1'b0;
    tick(1);
    check("alt_accept", out_valid, 0);

    // back-pressure: second window dropped
    out_ready = 1'b0; en = 1'b1; win_len = 8'd1; set_pair(1'b1, 1'b1);
    tick(2);
    check("bp_valid", out_valid, 1);
    check("bp_cnt", cnt_out, 4);
    check("bp_trans", trans_out, 1);
    set_pair(1'b0, 1'b1);
    tick(1);
    check("bp_stable_cnt", cnt_out, 4);
    check("bp_no_overrun_yet", overrun, 0);
    tick(1);
    check("bp_overrun", overrun, 1);
    check("bp_kept_cnt", cnt_out, 4);
    check("bp_kept_trans", trans_out, 1);
    check("bp_kept_valid", out_valid, 1);
    en = 1'b0; out_ready = 1'b1;
    tick(1);
    check("bp_accept", out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    check("bp_hold_cnt", cnt_out, 4);

    // max window, all ones; prev is 1 so no transitions
    en = 1'b1; win_len = 8'd255; set_pair(1'b1, 1'b1);
    tick(255);
    check("max_not_yet", out_valid, 0);
    tick(1);
    check("max_valid", out_valid, 1);
    check("max_cnt", cnt_out, 512);
    check("max_trans", trans_out, 0);
    en = 1'b0;
    tick(1);
    check("max_accept", out_valid, 0);

    // partial window discarded, next window counts from zero
    out_ready = 1'b0; en = 1'b1; win_len = 8'd3; set_pair(1'b1, 1'b1);
    tick(2);
    en = 1'b0; set_pair(1'b0, 1'b0);
    tick(1);
    check("part_no_result", out_valid, 0);
    en = 1'b1; set_pair(1'b1, 1'b0);
    tick(3);
    check("part_not_yet", out_valid, 0);
    tick(1);
    check("part_valid", out_valid, 1);
    check("part_cnt", cnt_out, 4);
    check("part_trans", trans_out, 7);

    // reset mid-window with a result pending
    set_pair(1'b1, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mrst_valid", out_valid, 0);
    check("mrst_cnt", cnt_out, 0);
    check("mrst_trans", trans_out, 0);
    check("mrst_overrun", overrun, 0);
    rst = 1'b0; win_len = 8'd0; out_ready = 1'b1;
    tick(1);
    check("mrst_prev_cnt", cnt_out, 2);
    check("mrst_prev_trans", trans_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
